// File: rtl/multdiv_iter_unit.sv
// rtl/multdiv_iter_unit.sv - iterative radix-2 signed/unsigned multiply/divide unit
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (ready only while idle)
//   in_op                  0 = multiply, 1 = divide
//   in_signed              1 = two's-complement operands
//   in_a, in_b             multiplicand/dividend, multiplier/divisor
//   cancel                 flush: drop the current operation or result
//   out_valid / out_ready  result handshake, result held until taken
//   out_lo, out_hi         product low/high word, or quotient/remainder
//   out_exception          multiply overflow, divide overflow or divide-by-zero
//   busy                   unit is not idle

module multdiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_exception,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic             op_r;
    logic             sgn_r;
    logic             neg_lo_r;   // product sign, or quotient sign
    logic             neg_hi_r;   // remainder sign (dividend sign)
    logic             dz_r;
    logic             ovf_r;
    logic [WIDTH-1:0] a_raw_r;
    logic [WIDTH-1:0] mag_r;      // multiplicand magnitude, or divisor magnitude
    logic [WIDTH-1:0] hi_r;       // partial product high half, or partial remainder
    logic [WIDTH-1:0] lo_r;       // multiplier shifting out / product low, or dividend -> quotient

    logic             accept;
    logic             iter_last;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && (state == IDLE) && !cancel;
    // The count reaches WIDTH only after all iterations; that edge finalises.
    assign iter_last = (cnt == CW'(WIDTH));

    // Operand magnitudes and signs at acceptance
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = in_signed && in_a[WIDTH-1];
    assign b_neg = in_signed && in_b[WIDTH-1];
    assign a_mag = a_neg ? (-in_a) : in_a;
    assign b_mag = b_neg ? (-in_b) : in_b;

    // Shift-add multiply step: add multiplicand when the low multiplier bit is set,
    // then shift the {carry, hi, lo} chain right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});

    // Restoring divide step: bring the next dividend bit into the remainder and
    // subtract the divisor when it fits. When it fits the difference is below
    // the divisor, so the low WIDTH bits of a modular subtract are exact.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {hi_r, lo_r[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_r});
    assign div_sub   = div_shift[WIDTH-1:0] - mag_r;

    // Sign correction applied on the finalising edge
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic               mul_exc;

    assign prod   = {hi_r, lo_r};
    assign prod_s = neg_lo_r ? (-prod) : prod;
    assign quot_s = neg_lo_r ? (-lo_r) : lo_r;
    assign rem_s  = neg_hi_r ? (-hi_r) : hi_r;
    assign mul_exc = sgn_r ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                           : (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (iter_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            op_r          <= 1'b0;
            sgn_r         <= 1'b0;
            neg_lo_r      <= 1'b0;
            neg_hi_r      <= 1'b0;
            dz_r          <= 1'b0;
            ovf_r         <= 1'b0;
            a_raw_r       <= '0;
            mag_r         <= '0;
            hi_r          <= '0;
            lo_r          <= '0;
            out_valid     <= 1'b0;
            out_lo        <= '0;
            out_hi        <= '0;
            out_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        op_r     <= in_op;
                        sgn_r    <= in_signed;
                        neg_lo_r <= a_neg ^ b_neg;
                        neg_hi_r <= in_op ? a_neg : (a_neg ^ b_neg);
                        dz_r     <= in_op && (in_b == '0);
                        ovf_r    <= in_op && in_signed
                                    && (in_a == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (in_b == {WIDTH{1'b1}});
                        a_raw_r  <= in_a;
                        hi_r     <= '0;
                        if (in_op) begin
                            lo_r  <= a_mag;
                            mag_r <= b_mag;
                        end else begin
                            lo_r  <= b_mag;
                            mag_r <= a_mag;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt <= '0;
                    end else if (iter_last) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        if (!op_r) begin
                            out_lo        <= prod_s[WIDTH-1:0];
                            out_hi        <= prod_s[2*WIDTH-1:WIDTH];
                            out_exception <= mul_exc;
                        end else if (dz_r) begin
                            out_lo        <= '0;
                            out_hi        <= a_raw_r;
                            out_exception <= 1'b1;
                        end else begin
                            out_lo        <= quot_s;
                            out_hi        <= rem_s;
                            out_exception <= ovf_r;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (!op_r) begin
                            hi_r <= mul_sum[WIDTH:1];
                            lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                        end else if (div_ge) begin
                            hi_r <= div_sub;
                            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_r <= div_shift[WIDTH-1:0];
                            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (cancel || out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
